// File: rtl/gpu_pkg.sv
// Shared types and default widths for the GPU fetch path.
// Imported by instruction_fetcher.
package gpu_pkg;

    localparam int PROGRAM_MEM_ADDR_BITS = 8;
    localparam int PROGRAM_MEM_DATA_BITS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        FETCHED = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: one memory read per accepted fetch_req,
// holds the word with a done flag until the decoder acks it.
module instruction_fetcher
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = PROGRAM_MEM_ADDR_BITS,
    parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [ADDR_BITS-1:0] pc,
    input  logic                 flush,
    input  logic                 instr_ack,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic [DATA_BITS-1:0] instruction,
    output logic                 instr_done,
    output logic                 busy,
    output logic [1:0]           fetch_state
);

    fetch_state_t         r_state;
    fetch_state_t         w_state_n;
    logic                 w_load_addr;
    logic                 w_load_instr;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_instr;

    // Next state plus load strobes for the address and instruction registers
    always_comb begin
        w_state_n    = r_state;
        w_load_addr  = 1'b0;
        w_load_instr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (fetch_req) begin
                    w_state_n   = REQUEST;
                    w_load_addr = 1'b1;
                end
            end
            REQUEST: begin
                if (flush) begin
                    w_state_n = mem_read_ready ? IDLE : DISCARD;
                end else if (mem_read_ready) begin
                    w_state_n    = FETCHED;
                    w_load_instr = 1'b1;
                end
            end
            DISCARD: begin
                if (mem_read_ready) begin
                    w_state_n = IDLE;
                end
            end
            FETCHED: begin
                if (flush) begin
                    w_state_n = IDLE;
                end else if (instr_ack && fetch_req) begin
                    w_state_n   = REQUEST;
                    w_load_addr = 1'b1;
                end else if (instr_ack) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // State, latched fetch address and captured instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_load_addr) begin
                r_addr <= pc;
            end
            if (w_load_instr) begin
                r_instr <= mem_read_data;
            end
        end
    end

    assign mem_read_valid   = (r_state == REQUEST) || (r_state == DISCARD);
    assign mem_read_address = r_addr;
    assign instruction      = r_instr;
    assign instr_done       = (r_state == FETCHED);
    assign busy             = (r_state != IDLE);
    assign fetch_state      = r_state;

    // An outstanding read keeps its request and address until the handshake completes
    a_req_hold: assert property (
        @(posedge clk) disable iff (reset)
        (mem_read_valid && !mem_read_ready)
            |=> (mem_read_valid && $stable(mem_read_address))
    );

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed table-driven bench for instruction_fetcher,
// plus a hand-written latency sequence.
module tb_instruction_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [7:0]  pc;
    logic        flush;
    logic        instr_ack;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [15:0] instruction;
    logic        instr_done;
    logic        busy;
    logic [1:0]  fetch_state;

    int n_pass = 0;
    int n_total = 0;

    instruction_fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_req        (fetch_req),
        .pc               (pc),
        .flush            (flush),
        .instr_ack        (instr_ack),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .instruction      (instruction),
        .instr_done       (instr_done),
        .busy             (busy),
        .fetch_state      (fetch_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic [7:0]  pc;
        logic        fl;
        logic        ack;
        logic        rdy;
        logic [15:0] data;
        logic [1:0]  st;
        logic        v;
        logic [7:0]  addr;
        logic [15:0] instr;
        logic        d;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset          = v.rst;
        fetch_req      = v.req;
        pc             = v.pc;
        flush          = v.fl;
        instr_ack      = v.ack;
        mem_read_ready = v.rdy;
        mem_read_data  = v.data;
    endtask

    initial begin
        vec_t idle_v;
        int   lat;

        //            rst req pc     fl ack rdy data      st  v  addr   instr     d
        tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000, 0});
        // zero-wait fetch
        tbl.push_back('{0, 1, 8'h05, 0, 0, 0, 16'h0000, 1, 1, 8'h05, 16'h0000, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 16'hA1B2, 2, 0, 8'h05, 16'hA1B2, 1});
        // back-to-back ack + fetch_req
        tbl.push_back('{0, 1, 8'h06, 0, 1, 0, 16'h0000, 1, 1, 8'h06, 16'hA1B2, 0});
        // four wait states, fetch_req ignored meanwhile
        tbl.push_back('{0, 1, 8'h09, 0, 0, 0, 16'h0000, 1, 1, 8'h06, 16'hA1B2, 0});
        tbl.push_back('{0, 1, 8'h09, 0, 0, 0, 16'h0000, 1, 1, 8'h06, 16'hA1B2, 0});
        tbl.push_back('{0, 0, 8'h09, 0, 0, 0, 16'h0000, 1, 1, 8'h06, 16'hA1B2, 0});
        tbl.push_back('{0, 0, 8'h09, 0, 0, 0, 16'h0000, 1, 1, 8'h06, 16'hA1B2, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 16'h1234, 2, 0, 8'h06, 16'h1234, 1});
        // fetch_req without ack ignored, then ack alone -> IDLE
        tbl.push_back('{0, 1, 8'h0A, 0, 0, 0, 16'h0000, 2, 0, 8'h06, 16'h1234, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 16'h0000, 0, 0, 8'h06, 16'h1234, 0});
        // flush without ready -> DISCARD, req ignored there
        tbl.push_back('{0, 1, 8'h10, 0, 0, 0, 16'h0000, 1, 1, 8'h10, 16'h1234, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 16'h0000, 3, 1, 8'h10, 16'h1234, 0});
        tbl.push_back('{0, 1, 8'h20, 0, 0, 0, 16'h0000, 3, 1, 8'h10, 16'h1234, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 16'hFFFF, 0, 0, 8'h10, 16'h1234, 0});
        // flush in IDLE has no effect
        tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 16'h0000, 0, 0, 8'h10, 16'h1234, 0});
        // top address, flush and ready together
        tbl.push_back('{0, 1, 8'hFF, 0, 0, 0, 16'h0000, 1, 1, 8'hFF, 16'h1234, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 1, 16'hBEEF, 0, 0, 8'hFF, 16'h1234, 0});
        // flush beats ack + req in FETCHED
        tbl.push_back('{0, 1, 8'h30, 0, 0, 0, 16'h0000, 1, 1, 8'h30, 16'h1234, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 16'h5A5A, 2, 0, 8'h30, 16'h5A5A, 1});
        tbl.push_back('{0, 1, 8'h40, 1, 1, 1, 16'h0000, 0, 0, 8'h30, 16'h5A5A, 0});
        // reset mid-request, late ready ignored
        tbl.push_back('{0, 1, 8'h77, 0, 0, 0, 16'h0000, 1, 1, 8'h77, 16'h5A5A, 0});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 1, 16'h9999, 0, 0, 8'h00, 16'h0000, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            chk("state", i, 32'(fetch_state), 32'(tbl[i].st));
            chk("valid", i, 32'(mem_read_valid), 32'(tbl[i].v));
            chk("addr", i, 32'(mem_read_address), 32'(tbl[i].addr));
            chk("instr", i, 32'(instruction), 32'(tbl[i].instr));
            chk("done", i, 32'(instr_done), 32'(tbl[i].d));
            chk("busy", i, 32'(busy), 32'(tbl[i].st != 2'd0));
        end

        // Zero-wait latency: done must appear 2 edges after the request edge
        idle_v = '{0, 1, 8'h42, 0, 0, 0, 16'h0000, 0, 0, 8'h00, 16'h0000, 0};
        drive(idle_v);
        @(posedge clk);
        #1;
        fetch_req      = 1'b0;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hC3C3;
        lat = 1;
        while (!instr_done && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 100, 32'(lat), 32'd2);
        chk("lat_instr", 100, 32'(instruction), 32'h0000C3C3);
        chk("lat_addr", 100, 32'(mem_read_address), 32'h00000042);
        mem_read_ready = 1'b0;
        instr_ack      = 1'b1;
        @(posedge clk);
        #1;
        instr_ack = 1'b0;
        chk("lat_idle", 101, 32'(fetch_state), 32'd0);
        chk("lat_keep", 101, 32'(instruction), 32'h0000C3C3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
